weight_loader: RTL and testbench

WEIGHT_LOADER -- requirements
Module: weight_loader

---
 rtl/weight_loader.sv | 122 ++++++++++++
 tb/tb_weight_loader.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/weight_loader.sv
// ============================================================================
//  weight_loader -- bursts words out of a zero-latency ROM into a registered
//                   valid/ready stream for the downstream conv stage.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module weight_loader #(
    parameter int ADDR_WIDTH = 6,
    parameter int ROM_DEPTH  = 64,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH:0]   len,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic [DATA_WIDTH-1:0] rom_data,
    output logic [DATA_WIDTH-1:0] weight_o,
    output logic                  weight_valid,
    input  logic                  weight_ready,
    output logic                  weight_last,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

    // Requests longer than the ROM are clamped so no word is fetched twice.
    localparam logic [ADDR_WIDTH:0] c_max_len = (ADDR_WIDTH+1)'(ROM_DEPTH);
    localparam logic [ADDR_WIDTH:0] c_one     = (ADDR_WIDTH+1)'(1);

    state_t                  state_q,  state_d;
    logic [ADDR_WIDTH-1:0]   addr_q,   addr_d;
    logic [ADDR_WIDTH:0]     remain_q, remain_d;
    logic [DATA_WIDTH-1:0]   weight_q, weight_d;
    logic                    valid_q,  valid_d;
    logic                    last_q,   last_d;

    logic                    w_fetch;
    logic                    w_handshake;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            remain_q <= '0;
            weight_q <= '0;
            valid_q  <= 1'b0;
            last_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            remain_q <= remain_d;
            weight_q <= weight_d;
            valid_q  <= valid_d;
            last_q   <= last_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        remain_d    = remain_q;
        weight_d    = weight_q;
        valid_d     = valid_q;
        last_d      = last_q;
        w_handshake = valid_q && weight_ready;
        // Refill the output register whenever it is empty or being drained.
        w_fetch     = (state_q == LOAD) && (remain_q != '0) && (!valid_q || weight_ready);

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (len == '0) begin
                        state_d = DONE;
                    end else begin
                        state_d  = LOAD;
                        addr_d   = base_addr;
                        remain_d = (len > c_max_len) ? c_max_len : len;
                    end
                end
            end
            LOAD: begin
                if (w_fetch) begin
                    weight_d = rom_data;
                    valid_d  = 1'b1;
                    addr_d   = addr_q + 1'b1;
                    remain_d = remain_q - c_one;
                    last_d   = (remain_q == c_one);
                end else if (w_handshake) begin
                    valid_d = 1'b0;
                    last_d  = 1'b0;
                end
                if (w_handshake && last_q) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign rom_addr     = addr_q;
    assign weight_o     = weight_q;
    assign weight_valid = valid_q;
    assign weight_last  = last_q;
    assign busy         = (state_q != IDLE);
    assign done         = (state_q == DONE);

endmodule

`default_nettype wire

// File: tb/tb_weight_loader.sv
// Scoreboard bench for weight_loader: stimulus pushes expected words derived
// from a ROM array, a negedge monitor pops and compares on every handshake.
`default_nettype none

module tb_weight_loader;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [5:0]  base_addr;
    logic [6:0]  blen;
    logic [5:0]  rom_addr;
    logic [31:0] rom_data;
    logic [31:0] weight_o;
    logic        weight_valid;
    logic        weight_ready;
    logic        weight_last;
    logic        busy;
    logic        done;

    logic [31:0] rom [64];
    assign rom_data = rom[rom_addr];

    weight_loader #(
        .ADDR_WIDTH(6),
        .ROM_DEPTH (64),
        .DATA_WIDTH(32)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .base_addr   (base_addr),
        .len         (blen),
        .rom_addr    (rom_addr),
        .rom_data    (rom_data),
        .weight_o    (weight_o),
        .weight_valid(weight_valid),
        .weight_ready(weight_ready),
        .weight_last (weight_last),
        .busy        (busy),
        .done        (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic        last;
        logic [5:0]  addr_next;
    } exp_t;

    exp_t   q[$];
    int     n_checks = 0;
    int     n_pass   = 0;
    int     hs_cnt   = 0;
    int     bursts_done = 0;
    int     abort_cnt  = 0;
    int     abort_seen = 0;
    logic   zlen_req = 1'b0;
    longint done_time = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp)
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        else
            n_pass++;
    endtask

    // ---------------- monitor / scoreboard ----------------
    logic        done_due = 1'b0;
    logic        done_due_next;
    logic        stall_prev = 1'b0;
    logic [31:0] p_data;
    logic        p_last;
    logic [5:0]  p_addr;
    exp_t        e;

    always @(negedge clk) begin
        if (!rst_n) begin
            stall_prev = 1'b0;
            done_due   = 1'b0;
        end else begin
            if (abort_cnt != abort_seen) begin
                q.delete();
                done_due   = 1'b0;
                stall_prev = 1'b0;
                abort_seen = abort_cnt;
            end
            chk("done", done, done_due);
            if (done) begin
                bursts_done++;
                done_time = $time;
                chk("busy_in_done", busy, 1'b1);
            end
            if (stall_prev) begin
                chk("hold_valid", weight_valid, 1'b1);
                chk("hold_data", weight_o, p_data);
                chk("hold_last", weight_last, p_last);
                chk("hold_addr", rom_addr, p_addr);
            end
            done_due_next = 1'b0;
            if (weight_valid) begin
                chk("busy_while_valid", busy, 1'b1);
                if (q.size() == 0) begin
                    chk("spurious_valid", weight_valid, 1'b0);
                end else if (weight_ready) begin
                    e = q.pop_front();
                    chk("word_data", weight_o, e.data);
                    chk("word_last", weight_last, e.last);
                    chk("rom_addr_after_fetch", rom_addr, e.addr_next);
                    hs_cnt++;
                    if (e.last) done_due_next = 1'b1;
                end
            end
            if (start && zlen_req) done_due_next = 1'b1;
            done_due   = done_due_next;
            stall_prev = weight_valid && !weight_ready;
            p_data = weight_o;
            p_last = weight_last;
            p_addr = rom_addr;
        end
    end

    // ---------------- stimulus ----------------
    function automatic logic rdy(input int mode, input logic [15:0] pat, input int k);
        if (mode == 1) return ($urandom % 4) != 0;
        if (mode == 2) return (k < 16) ? pat[k] : 1'b1;
        return 1'b1;
    endfunction

    task automatic push_burst(input int base, input int n);
        exp_t it;
        for (int i = 0; i < n; i++) begin
            it.data      = rom[(base + i) % 64];
            it.last      = (i == n - 1);
            it.addr_next = 6'((base + i + 1) % 64);
            q.push_back(it);
        end
    endtask

    task automatic run_burst(input int base, input int n, input int mode,
                             input logic [15:0] pat, input bit inject);
        longint t_start;
        int     nd;
        int     k;
        @(posedge clk); #1;
        nd        = bursts_done;
        start     = 1'b1;
        base_addr = 6'(base);
        blen      = 7'(n);
        zlen_req  = (n == 0);
        t_start   = $time - 1 + 10;
        push_burst(base, n);
        @(posedge clk); #1;
        start     = 1'b0;
        zlen_req  = 1'b0;
        base_addr = 6'($urandom);
        blen      = 7'($urandom % 65);
        k = 0;
        while (bursts_done == nd && k < 2000) begin
            weight_ready = rdy(mode, pat, k);
            start = inject && (k == 3);
            if (start) begin
                base_addr = 6'($urandom);
                blen      = 7'(1 + $urandom % 64);
            end
            @(posedge clk); #1;
            k++;
        end
        start = 1'b0;
        chk("burst_completed", 64'(bursts_done - nd), 64'd1);
        chk("queue_drained", 64'(q.size()), 64'd0);
        if (mode == 0)
            chk("done_latency", 64'(done_time - t_start),
                (n == 0) ? 64'd5 : 64'((n + 1) * 10 + 5));
    endtask

    task automatic run_abort();
        int nd;
        int h0;
        int k;
        @(posedge clk); #1;
        nd = bursts_done;
        h0 = hs_cnt;
        start = 1'b1; base_addr = 6'd0; blen = 7'd10;
        push_burst(0, 10);
        @(posedge clk); #1;
        start = 1'b0;
        weight_ready = 1'b1;
        k = 0;
        while (hs_cnt - h0 < 2 && k < 100) begin
            @(posedge clk); #1;
            k++;
        end
        chk("abort_reached_word3", 64'(hs_cnt - h0), 64'd2);
        #1 rst_n = 1'b0;
        #1;
        chk("async_rst_rom_addr", rom_addr, 6'd0);
        chk("async_rst_weight_o", weight_o, 32'd0);
        chk("async_rst_valid", weight_valid, 1'b0);
        chk("async_rst_last", weight_last, 1'b0);
        chk("async_rst_busy", busy, 1'b0);
        chk("async_rst_done", done, 1'b0);
        #1 rst_n = 1'b1;
        abort_cnt++;
        repeat (4) @(posedge clk);
        #1;
        chk("no_done_after_abort", 64'(bursts_done - nd), 64'd0);
        chk("idle_after_abort", busy, 1'b0);
    endtask

    initial begin
        int base, n, mode, r;
        logic [15:0] pat;
        rst_n = 1'b0; start = 1'b0; base_addr = '0; blen = '0; weight_ready = 1'b0;
        for (int i = 0; i < 64; i++) rom[i] = 32'(i + 1);
        #1;
        chk("reset_rom_addr", rom_addr, 6'd0);
        chk("reset_weight_o", weight_o, 32'd0);
        chk("reset_valid", weight_valid, 1'b0);
        chk("reset_last", weight_last, 1'b0);
        chk("reset_busy", busy, 1'b0);
        chk("reset_done", done, 1'b0);
        #20 rst_n = 1'b1;

        run_burst(0, 6, 0, 16'hFFFF, 1'b0);
        run_burst(62, 4, 0, 16'hFFFF, 1'b0);
        run_burst(25, 3, 2, 16'hFFF3, 1'b0);
        run_burst(0, 0, 0, 16'hFFFF, 1'b0);
        run_burst(10, 12, 0, 16'hFFFF, 1'b1);
        run_abort();
        run_burst(5, 2, 0, 16'hFFFF, 1'b0);
        run_burst(17, 64, 1, 16'hFFFF, 1'b0);

        for (int t = 0; t < 25; t++) begin
            for (int i = 0; i < 64; i++) rom[i] = $urandom;
            base = $urandom % 64;
            r    = $urandom % 8;
            n    = (r == 0) ? 0 : (r == 1) ? 64 : 1 + ($urandom % 20);
            mode = $urandom % 3;
            pat  = 16'($urandom);
            run_burst(base, n, mode, pat, (n >= 6) && (($urandom % 3) == 0));
        end

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
